// File: rtl/serial_collector_if.sv
// Bundles the serial link inputs, the word handshake and the display/status
// outputs of serial_collector.
interface serial_collector_if #(
  parameter int WIDTH = 8
);
  logic             bitin;
  logic             strobe;
  logic             ack;
  logic             abort;
  logic [WIDTH-1:0] partial;
  logic [4:0]       count;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             done;
  logic             overrun;
  logic [6:0]       hexnumber1;
  logic [6:0]       hexnumber2;

  modport master (
    output bitin, strobe, ack, abort,
    input  partial, count, data, valid, done, overrun, hexnumber1, hexnumber2
  );

  modport slave (
    input  bitin, strobe, ack, abort,
    output partial, count, data, valid, done, overrun, hexnumber1, hexnumber2
  );
endinterface

// File: rtl/serial_collector.sv
// LSB-first serial-to-parallel receiver with a double-buffered holding
// register, valid/ack handshake, overrun flag and seven-segment display.
module hex2seven_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    seg = 7'h7f;
    case (hex)
      4'h0: seg = ~7'h3f;
      4'h1: seg = ~7'h06;
      4'h2: seg = ~7'h5b;
      4'h3: seg = ~7'h4f;
      4'h4: seg = ~7'h66;
      4'h5: seg = ~7'h6d;
      4'h6: seg = ~7'h7d;
      4'h7: seg = ~7'h07;
      4'h8: seg = ~7'h7f;
      4'h9: seg = ~7'h6f;
      4'ha: seg = ~7'h77;
      4'hb: seg = ~7'h7c;
      4'hc: seg = ~7'h39;
      4'hd: seg = ~7'h5e;
      4'he: seg = ~7'h79;
      4'hf: seg = ~7'h71;
    endcase
  end
endmodule

module serial_collector #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  serial_collector_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY      = 2'b00,
    RECV       = 2'b01,
    READY      = 2'b10,
    READY_RECV = 2'b11
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] partial_q;
  logic [WIDTH-1:0] data_q;
  logic [4:0]       count_q;
  logic             done_q;
  logic             overrun_q;
  logic             valid;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;
  logic [15:0]      data_ext;

  assign last_bit = (count_q == 5'(WIDTH - 1));
  assign shifted  = {bus.bitin, partial_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= next_state;
  end

  // The state is {holding-register valid, partial word in progress}; abort
  // only drops the partial word, so the valid half survives it.
  always_comb begin
    logic next_valid;
    logic next_recv;
    next_valid = (state == READY) || (state == READY_RECV);
    next_recv  = (state == RECV)  || (state == READY_RECV);
    if (bus.abort) begin
      next_recv = 1'b0;
    end else begin
      if (bus.strobe && last_bit) next_valid = 1'b1;
      else if (bus.ack)           next_valid = 1'b0;
      if (bus.strobe)             next_recv  = !last_bit;
    end
    next_state = state_t'({next_valid, next_recv});
  end

  always_comb begin
    valid = (state == READY) || (state == READY_RECV);
  end

  // A completing strobe with ack in the same cycle retires the old word, so
  // only an unacknowledged valid word counts as overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      partial_q <= '0;
      count_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        partial_q <= '0;
        count_q   <= '0;
        overrun_q <= 1'b0;
      end else if (bus.strobe) begin
        if (last_bit) begin
          data_q    <= shifted;
          partial_q <= '0;
          count_q   <= '0;
          done_q    <= 1'b1;
          if (valid && !bus.ack) overrun_q <= 1'b1;
        end else begin
          partial_q <= shifted;
          count_q   <= count_q + 5'd1;
        end
      end
    end
  end

  assign bus.partial = partial_q;
  assign bus.count   = count_q;
  assign bus.data    = data_q;
  assign bus.valid   = valid;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

  // Zero-extension makes display bits above WIDTH read as 0.
  assign data_ext = 16'(data_q);

  hex2seven_seg u_hex_lo (
    .hex(data_ext[3:0]),
    .seg(bus.hexnumber1)
  );

  hex2seven_seg u_hex_hi (
    .hex(data_ext[7:4]),
    .seg(bus.hexnumber2)
  );
endmodule

// File: tb/tb_serial_collector.sv
// Self-checking bench for serial_collector: directed scenarios plus a random
// run compared against a queue-based model of the received bit stream.
module tb_serial_collector;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   tests_run = 0;
  int   failures  = 0;

  serial_collector_if #(.WIDTH(W)) bus ();

  serial_collector #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit           m_bits[$];
  logic [W-1:0] m_data;
  bit           m_valid;
  bit           m_done;
  bit           m_over;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3f; 4'h1: p = 7'h06; 4'h2: p = 7'h5b; 4'h3: p = 7'h4f;
      4'h4: p = 7'h66; 4'h5: p = 7'h6d; 4'h6: p = 7'h7d; 4'h7: p = 7'h07;
      4'h8: p = 7'h7f; 4'h9: p = 7'h6f; 4'ha: p = 7'h77; 4'hb: p = 7'h7c;
      4'hc: p = 7'h39; 4'hd: p = 7'h5e; 4'he: p = 7'h79; default: p = 7'h71;
    endcase
    return ~p;
  endfunction

  // Bits received so far sit at the top of the shift register, oldest lowest.
  function automatic logic [W-1:0] model_partial();
    logic [W-1:0] p = '0;
    int k = m_bits.size();
    for (int i = 0; i < k; i++) p[W-k+i] = m_bits[i];
    return p;
  endfunction

  task automatic drive(input bit rst_n, input bit b, input bit s, input bit a, input bit ab);
    logic [W-1:0] word;
    reset      = rst_n;
    bus.bitin  = b;
    bus.strobe = s;
    bus.ack    = a;
    bus.abort  = ab;
    @(posedge clk);
    if (!rst_n) begin
      m_bits.delete();
      m_data = '0; m_valid = 0; m_done = 0; m_over = 0;
    end else if (ab) begin
      m_bits.delete();
      m_over = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (s) m_bits.push_back(b);
      if (m_bits.size() == W) begin
        word = '0;
        for (int i = 0; i < W; i++) word[i] = m_bits[i];
        m_bits.delete();
        if (m_valid && !a) m_over = 1;
        m_data = word; m_valid = 1; m_done = 1;
      end else if (a) begin
        m_valid = 0;
      end
    end
    #1;
    reset = 1'b1; bus.strobe = 0; bus.ack = 0; bus.abort = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
  endtask

  task automatic send_word(input logic [W-1:0] v, input int gap, input bit ack_last);
    for (int i = 0; i < W; i++) begin
      drive(1, v[i], 1, ack_last && (i == W - 1), 0);
      if (i != W - 1) idle(gap);
    end
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0);
    idle(1);
    tests_run++;
    if (bus.partial !== '0 || bus.count !== 5'd0 || bus.data !== '0) begin
      $display("[TB] FAIL reset_regs: partial=%h count=%0d data=%h, required 0/0/0",
               bus.partial, bus.count, bus.data);
      failures++;
    end
    tests_run++;
    if (bus.valid !== 1'b0 || bus.done !== 1'b0 || bus.overrun !== 1'b0) begin
      $display("[TB] FAIL reset_flags: valid=%b done=%b overrun=%b, required 0/0/0",
               bus.valid, bus.done, bus.overrun);
      failures++;
    end
    tests_run++;
    if (bus.hexnumber1 !== seg_of(4'h0) || bus.hexnumber2 !== seg_of(4'h0)) begin
      $display("[TB] FAIL reset_hex: hex1=%h hex2=%h, required %h/%h",
               bus.hexnumber1, bus.hexnumber2, seg_of(4'h0), seg_of(4'h0));
      failures++;
    end
  endtask

  task automatic test_word_receive();
    logic [7:0] v = 8'hA5;
    int dones = 0;
    for (int i = 0; i < W; i++) begin
      drive(1, v[i], 1, 0, 0);
      if (bus.done) dones++;
      tests_run++;
      if (bus.count !== 5'((i + 1) % W)) begin
        $display("[TB] FAIL word_count: bit %0d count=%0d, required %0d", i, bus.count, (i + 1) % W);
        failures++;
      end
      for (int j = 0; j < 3; j++) begin
        idle(1);
        if (bus.done) dones++;
      end
    end
    tests_run++;
    if (dones != 1) begin
      $display("[TB] FAIL word_done_pulses: saw %0d, required 1", dones);
      failures++;
    end
    tests_run++;
    if (bus.data !== 8'hA5 || bus.valid !== 1'b1) begin
      $display("[TB] FAIL word_data: data=%h valid=%b, required a5/1", bus.data, bus.valid);
      failures++;
    end
    tests_run++;
    if (bus.hexnumber2 !== seg_of(4'hA) || bus.hexnumber1 !== seg_of(4'h5)) begin
      $display("[TB] FAIL word_hex: hex2=%h hex1=%h, required %h/%h",
               bus.hexnumber2, bus.hexnumber1, seg_of(4'hA), seg_of(4'h5));
      failures++;
    end
    drive(1, 0, 0, 1, 0);
    tests_run++;
    if (bus.valid !== 1'b0 || bus.data !== 8'hA5) begin
      $display("[TB] FAIL word_ack: valid=%b data=%h, required 0/a5", bus.valid, bus.data);
      failures++;
    end
  endtask

  task automatic test_abort();
    logic [7:0] v = 8'h3C;
    int early = 0;
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 1);
    tests_run++;
    if (bus.count !== 5'd0 || bus.partial !== '0 || bus.data !== 8'hA5) begin
      $display("[TB] FAIL abort_clear: count=%0d partial=%h data=%h, required 0/00/a5",
               bus.count, bus.partial, bus.data);
      failures++;
    end
    for (int i = 0; i < W; i++) begin
      drive(1, v[i], 1, 0, 0);
      if (i < W - 1 && (bus.done || bus.valid)) early++;
    end
    tests_run++;
    if (early != 0) begin
      $display("[TB] FAIL abort_early: %0d early completions, required 0", early);
      failures++;
    end
    tests_run++;
    if (bus.data !== 8'h3C || bus.done !== 1'b1) begin
      $display("[TB] FAIL abort_word: data=%h done=%b, required 3c/1", bus.data, bus.done);
      failures++;
    end
    drive(1, 0, 0, 1, 0);
  endtask

  task automatic test_overrun();
    send_word(8'h11, 0, 0);
    send_word(8'h22, 1, 0);
    tests_run++;
    if (bus.data !== 8'h22 || bus.valid !== 1'b1 || bus.overrun !== 1'b1) begin
      $display("[TB] FAIL overrun_set: data=%h valid=%b overrun=%b, required 22/1/1",
               bus.data, bus.valid, bus.overrun);
      failures++;
    end
    drive(1, 0, 0, 1, 0);
    tests_run++;
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b1) begin
      $display("[TB] FAIL overrun_ack: valid=%b overrun=%b, required 0/1", bus.valid, bus.overrun);
      failures++;
    end
    drive(1, 0, 0, 0, 1);
    tests_run++;
    if (bus.overrun !== 1'b0) begin
      $display("[TB] FAIL overrun_abort: overrun=%b, required 0", bus.overrun);
      failures++;
    end
  endtask

  task automatic test_back_to_back_ack();
    send_word(8'h11, 0, 0);
    send_word(8'h77, 0, 1);
    tests_run++;
    if (bus.data !== 8'h77 || bus.valid !== 1'b1 || bus.overrun !== 1'b0 || bus.done !== 1'b1) begin
      $display("[TB] FAIL simul_ack: data=%h valid=%b overrun=%b done=%b, required 77/1/0/1",
               bus.data, bus.valid, bus.overrun, bus.done);
      failures++;
    end
    idle(1);
    tests_run++;
    if (bus.done !== 1'b0) begin
      $display("[TB] FAIL simul_done_drop: done=%b, required 0", bus.done);
      failures++;
    end
    drive(1, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0);
    tests_run++;
    if (bus.count !== 5'd0 || bus.partial !== '0 || bus.data !== '0 || bus.valid !== 1'b0) begin
      $display("[TB] FAIL midreset_clear: count=%0d partial=%h data=%h valid=%b, required 0/00/00/0",
               bus.count, bus.partial, bus.data, bus.valid);
      failures++;
    end
    send_word(8'hF0, 1, 0);
    tests_run++;
    if (bus.data !== 8'hF0 || bus.valid !== 1'b1) begin
      $display("[TB] FAIL midreset_word: data=%h valid=%b, required f0/1", bus.data, bus.valid);
      failures++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(59) != 0, $urandom_range(1), $urandom_range(2) != 0,
            $urandom_range(3) == 0, $urandom_range(24) == 0);
      tests_run++;
      if (bus.partial !== model_partial() || bus.count !== 5'(m_bits.size()) ||
          bus.data !== m_data || bus.valid !== m_valid || bus.done !== m_done ||
          bus.overrun !== m_over || bus.hexnumber1 !== seg_of(m_data[3:0]) ||
          bus.hexnumber2 !== seg_of(m_data[7:4])) begin
        $display("[TB] FAIL random_c%0d: got p=%h c=%0d d=%h v=%b dn=%b o=%b, required p=%h c=%0d d=%h v=%b dn=%b o=%b",
                 c, bus.partial, bus.count, bus.data, bus.valid, bus.done, bus.overrun,
                 model_partial(), m_bits.size(), m_data, m_valid, m_done, m_over);
        failures++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; bus.bitin = 0; bus.strobe = 0; bus.ack = 0; bus.abort = 0;
    #1;
    test_reset();
    test_word_receive();
    test_abort();
    test_overrun();
    test_back_to_back_ack();
    test_reset_mid_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule

// File: doc/serial_collector.md
# serial_collector

Serial-to-parallel receiver for the board's bit-shift link. It takes one bit per strobe, LSB first, and assembles them into a WIDTH-bit word. Each completed word is latched into a holding register with a valid/ack handshake and shown on two seven-segment digits. The strobe, ack and abort inputs are one-cycle pulses from `button` instances. The word format matches a right-shifting transmitter: the sender's bit 0 goes first, and the new bit enters at the MSB.

## Interface
- `WIDTH`, default 8: word length in bits; legal range 2..16.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `bitin`  input  1  serial data bit; sampled only in cycles where `strobe`=1.
- `strobe`  input  1  one-cycle pulse: shift `bitin` in.
- `ack`  input  1  one-cycle pulse: consumer has taken `data`.
- `abort`  input  1  one-cycle pulse: discard the partial word and clear `overrun`.
- `partial`  output  WIDTH  shift register contents (for LEDs).
- `count`  output  5  bits received in the current word, 0..WIDTH-1.
- `data`  output  WIDTH  last completed word.
- `valid`  output  1  `data` holds an unacknowledged word.
- `done`  output  1  one-cycle pulse when a word completes.
- `overrun`  output  1  sticky flag: a word completed while `valid`=1 and no `ack` arrived.
- `hexnumber1`  output  7  seven-segment pattern for `data[3:0]`, via `hex2seven_seg`.
- `hexnumber2`  output  7  seven-segment pattern for `data[7:4]`, via `hex2seven_seg`; bits at or above WIDTH read as 0.

## Operation
- FSM state is {valid, count!=0}:
  - EMPTY: valid=0, count=0.
  - RECV: valid=0, count>0.
  - READY: valid=1, count=0.
  - READY_RECV: valid=1, count>0.
- Priority per cycle: reset, then abort, then strobe and ack together.
- Reset (reset=0): partial=0, count=0, data=0, valid=0, done=0, overrun=0; state EMPTY.
- Abort: partial=0, count=0, overrun=0, done=0. data and valid are kept; strobe and ack in that cycle are ignored.
- Strobe with count<WIDTH-1: partial <= {bitin, partial[WIDTH-1:1]}; count <= count+1.
- Strobe with count=WIDTH-1 (word completes):
  - data <= {bitin, partial[WIDTH-1:1]}; partial <= 0; count <= 0; done=1 for that one cycle.
  - valid <= 1.
  - If valid was 1 and ack=0 in the same cycle: overrun <= 1 and data is overwritten.
- Ack with no completing strobe: valid <= 0. Ack while valid=0 has no effect.
- Ack in the same cycle as a completing strobe: the ack retires the old word, the new word loads, valid stays 1, overrun is unchanged.
- Collection continues while valid=1 (double buffering); a partial word is never lost by waiting for ack.
- overrun is cleared only by reset or abort.
- done is 0 in every cycle without a completing strobe.
- Back-to-back strobes, one per cycle, are legal.

## Timing
- All outputs except hexnumber1/2 are registered. hexnumber1/2 decode `data` combinationally.
- Latency: a strobe sampled at edge N is reflected in partial/count after edge N. The WIDTH-th strobe at edge N makes data, valid and done visible after edge N, and done drops after edge N+1.
- Ack at edge N clears valid after edge N.
- Reset at any point takes effect at the next edge, even mid-word or in a cycle with strobe or ack. During reset all inputs are ignored.
- count wraps WIDTH-1 to 0 on completion; it never reaches WIDTH.

## Test plan
- Reset: hold reset=0 for 2 cycles with strobe pulsing, then release -> partial=0, count=0, data=0x00, valid=0, done=0, overrun=0; both hex outputs show the `hex2seven_seg` pattern for 0.
- Word receive: with WIDTH=8, send bits 1,0,1,0,0,1,0,1, one strobe each, 3 idle cycles apart -> count steps 1..7 then returns to 0; data=0xA5, valid=1; done high for exactly one cycle; hexnumber2/1 show "A"/"5".
- Abort mid-word: send 5 bits, pulse abort, then send the full 0x3C -> count=0 after the abort; data=0x3C; no word completes early.
- Overrun: send 0x11 with no ack, then send 0x22 -> data=0x22, valid=1, overrun=1. Then pulse ack -> valid=0, overrun stays 1. Then pulse abort -> overrun=0.
- Simultaneous ack and completion: with 0x11 held valid, send 0x77 with ack asserted in the cycle of the 8th strobe -> data=0x77, valid=1, overrun=0, done pulses.
- Reset mid-word: after 3 bits, pulse reset=0 for 1 cycle, then send 0xF0 -> count=0 after the reset; data=0xF0 with no leftover bits from before the reset.
